// File: rtl/log2lin_pkg.sv
// Shared constants and stage payload types for the log2lin antilog pipeline.
package log2lin_pkg;

  // 2^(k/4) in Q1.12, plus the k=4 endpoint used for the last delta.
  localparam int T0    = 4096;
  localparam int T1    = 4871;
  localparam int T2    = 5793;
  localparam int T3    = 6889;
  localparam int T_END = 8192;

  localparam int FRAC_W    = 13;
  localparam int IDX_W     = 2;
  localparam int REM_W     = 11;
  localparam int EXP_W_DEF = 4;

  typedef struct packed {
    logic [FRAC_W-1:0]    base;
    logic [REM_W-1:0]     delta;
    logic [REM_W-1:0]     r;
    logic [EXP_W_DEF-1:0] e;
  } s1_payload_t;

  typedef struct packed {
    logic [FRAC_W-1:0]    y;
    logic [EXP_W_DEF-1:0] e;
  } s2_payload_t;

endpackage

// File: rtl/lut_exp_2to13.sv
// Combinational 4-entry 2^(k/4) table: base value and distance to the next entry.
module lut_exp_2to13
  import log2lin_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [FRAC_W-1:0] base,
  output logic [REM_W-1:0]  delta
);

  always_comb begin
    base  = FRAC_W'(T0);
    delta = REM_W'(T1 - T0);
    unique case (idx)
      2'd0: begin base = FRAC_W'(T0); delta = REM_W'(T1 - T0);    end
      2'd1: begin base = FRAC_W'(T1); delta = REM_W'(T2 - T1);    end
      2'd2: begin base = FRAC_W'(T2); delta = REM_W'(T3 - T2);    end
      2'd3: begin base = FRAC_W'(T3); delta = REM_W'(T_END - T3); end
      default: ;
    endcase
  end

endmodule

// File: rtl/log2lin_pipe.sv
// Three-stage elastic antilog pipeline: lookup, interpolate, scale by 2^e.
// LOG2LIN_INTERP_EN enables linear interpolation in S2; otherwise S2 passes the table base.
module log2lin_pipe
  import log2lin_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = log2lin_pkg::FRAC_W,
  parameter int OUT_W  = 2**EXP_W - 1 + 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [EXP_W+FRAC_W-1:0] in_log,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [OUT_W-1:0]        out_lin
);

  logic        s1_val, s2_val, s3_val;
  logic        s1_adv, s2_adv, s3_adv;
  s1_payload_t s1_q, s1_d;
  s2_payload_t s2_q, s2_d;

  logic [FRAC_W-1:0] lut_base;
  logic [REM_W-1:0]  lut_delta;

  // Each stage may load when it is empty or its content moves on this cycle.
  assign s3_adv  = !s3_val || out_rdy;
  assign s2_adv  = !s2_val || s3_adv;
  assign s1_adv  = !s1_val || s2_adv;
  assign in_rdy  = !s1_val || s1_adv;
  assign out_val = s3_val;

  lut_exp_2to13 u_lut (
    .idx   (in_log[FRAC_W-1 -: IDX_W]),
    .base  (lut_base),
    .delta (lut_delta)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.base  = lut_base;
    s1_d.delta = lut_delta;
    s1_d.r     = in_log[REM_W-1:0];
    s1_d.e     = in_log[FRAC_W +: EXP_W];
  end

`ifdef LOG2LIN_INTERP_EN
  logic [2*REM_W-1:0] prod;
  assign prod = s1_q.delta * s1_q.r;

  always_comb begin
    s2_d   = '0;
    s2_d.y = s1_q.base + FRAC_W'(prod[2*REM_W-1:REM_W]);
    s2_d.e = s1_q.e;
  end
`else
  always_comb begin
    s2_d   = '0;
    s2_d.y = s1_q.base;
    s2_d.e = s1_q.e;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_val <= 1'b0;
      s1_q   <= '0;
    end else if (s1_adv) begin
      s1_val <= in_val;
      if (in_val) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_val <= 1'b0;
      s2_q   <= '0;
    end else if (s2_adv) begin
      s2_val <= s1_val;
      if (s1_val) s2_q <= s2_d;
    end
  end

  // y < 8192 and e <= 2^EXP_W-1, so the shifted value always fits OUT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_val  <= 1'b0;
      out_lin <= '0;
    end else if (s3_adv) begin
      s3_val <= s2_val;
      if (s2_val) out_lin <= OUT_W'(s2_q.y) << s2_q.e;
    end
  end

endmodule

// File: tb/tb_log2lin_pipe.sv
// Self-checking bench for log2lin_pipe; expected values follow LOG2LIN_INTERP_EN.
module tb_log2lin_pipe;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 13;
  localparam int OUT_W  = 2**EXP_W - 1 + 13;

  logic                    clk;
  logic                    reset;
  logic                    in_val;
  logic                    in_rdy;
  logic [EXP_W+FRAC_W-1:0] in_log;
  logic                    out_val;
  logic                    out_rdy;
  logic [OUT_W-1:0]        out_lin;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_out = 0;
  logic [31:0] sbq[$];

  log2lin_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_log  (in_log),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_lin (out_lin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: 2^(e + f/8192) * 4096 from the quarter-octave table, optionally
  // interpolated linearly over the 2048-step remainder with floor division.
  function automatic logic [31:0] model(input logic [16:0] v);
    int unsigned tbl[5] = '{4096, 4871, 5793, 6889, 8192};
    int unsigned e = v[16:13];
    int unsigned k = v[12:11];
    int unsigned r = v[10:0];
    int unsigned y;
`ifdef LOG2LIN_INTERP_EN
    y = tbl[k] + ((tbl[k+1] - tbl[k]) * r) / 2048;
`else
    y = tbl[k];
    r = 0;
`endif
    return y * (32'd1 << e);
  endfunction

  function automatic logic [16:0] rand_log();
    logic [3:0]  e = 4'($urandom);
    logic [12:0] f = 13'($urandom);
    case ($urandom_range(0, 11))
      0: f = 13'h0000;
      1: f = 13'h1FFF;
      2: f = 13'h07FF;
      3: f = 13'h0800;
      default: ;
    endcase
    return {e, f};
  endfunction

  // Scoreboard: handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
    end else begin
      if (out_val && out_rdy) begin
        check("sb_avail", 32'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          check("sb_data", 32'(out_lin), sbq.pop_front());
          n_out++;
        end
      end
      if (in_val && in_rdy) sbq.push_back(model(in_log));
    end
  end

  task automatic drive_one(input string tag, input logic [3:0] e, input logic [12:0] f,
                           input logic [31:0] exp);
    int unsigned waited = 0;
    int unsigned lat;
    @(posedge clk); #1;
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_log  = {e, f};
    @(negedge clk);
    while (!in_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_acc"}, 32'(in_rdy), 1);
    @(posedge clk); #1;
    in_val = 1'b0;
    lat = 1;
    while (!out_val && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check(tag, 32'(out_lin), exp);
    @(posedge clk); #1;
  endtask

  task automatic backpressure();
    logic [16:0] items[6] = '{17'h00400, 17'h02C00, 17'h05FFF, 17'h0E123, 17'h1F7FF, 17'h10801};
    int unsigned idx = 0;
    int unsigned outs = 0;
    int unsigned gaps = 0;
    for (int cyc = 0; cyc < 40 && outs < 6; cyc++) begin
      @(posedge clk); #1;
      out_rdy = (cyc >= 5);
      in_val  = (idx < 6);
      if (idx < 6) in_log = items[idx];
      @(negedge clk);
      if (cyc == 3) begin
        check("bp_full_rdy", 32'(in_rdy), 0);
        check("bp_accepts", idx, 3);
      end
      if (cyc == 5) check("bp_nobubble", 32'(in_rdy), 1);
      if (cyc >= 5) begin
        if (!out_val) gaps++;
        else outs++;
      end
      if (in_val && in_rdy) idx++;
    end
    @(posedge clk); #1;
    in_val = 1'b0;
    check("bp_outs", outs, 6);
    check("bp_gaps", gaps, 0);
  endtask

  task automatic stress();
    int unsigned sent = 0;
    int unsigned cyc = 0;
    int unsigned out0 = n_out;
    logic pending = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      out_rdy = ($urandom_range(0, 3) != 0) || (cyc[9:8] == 2'b01 && $urandom_range(0, 1) == 0);
      if (cyc[9:8] == 2'b10) out_rdy = ($urandom_range(0, 4) == 0);
      if (!pending) begin
        in_val = (sent < 1000) && ($urandom_range(0, 2) != 0);
        in_log = rand_log();
      end
      @(negedge clk);
      if (in_val && in_rdy) begin
        sent++;
        pending = 1'b0;
      end else begin
        pending = in_val;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stress_sent", sent, 1000);
    check("stress_out", n_out - out0, 1000);
    check("stress_drained", 32'(sbq.size()), 0);
  endtask

  task automatic reset_mid();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_val = 1'b1;
      in_log = rand_log();
    end
    @(posedge clk); #1;
    in_val = 1'b0;
    check("rst_pre_full", 32'(out_val), 1);
    check("rst_pre_rdy", 32'(in_rdy), 0);
    reset = 1'b1;
    #1;
    check("rst_async_val", 32'(out_val), 0);
    check("rst_async_lin", 32'(out_lin), 0);
    check("rst_async_rdy", 32'(in_rdy), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rel_rdy", 32'(in_rdy), 1);
    check("rst_rel_val", 32'(out_val), 0);
    drive_one("rst_next", 4'd1, 13'h0000, 32'd8192);
  endtask

  initial begin
    reset   = 1'b1;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    in_log  = '0;
    #12;
    check("reset_val", 32'(out_val), 0);
    check("reset_lin", 32'(out_lin), 0);
    check("reset_rdy", 32'(in_rdy), 1);
    @(posedge clk); #1;
    reset = 1'b0;

    drive_one("basic",   4'd0,  13'h0000, 32'd4096);
    drive_one("exp3",    4'd3,  13'h0000, 32'd32768);
    drive_one("idx2",    4'd0,  13'h1000, 32'd5793);
    drive_one("exp15",   4'd15, 13'h1800, 32'd225738752);
`ifdef LOG2LIN_INTERP_EN
    drive_one("interp",  4'd0,  13'h0400, 32'd4483);
    drive_one("top",     4'd0,  13'h1FFF, 32'd8191);
`else
    drive_one("interp",  4'd0,  13'h0400, 32'd4096);
    drive_one("top",     4'd0,  13'h1FFF, 32'd6889);
`endif

    backpressure();
    stress();
    reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
